// File: rtl/heat_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// heat_pkg : shared widths and scheduler state encoding for the heat solver
// Rev 1.0
// ----------------------------------------------------------------------------
package heat_pkg;

  localparam int DEF_ROW_W  = 8;
  localparam int DEF_ITER_W = 16;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] INIT_WAIT = 3'd1;
  localparam logic [2:0] ISSUE     = 3'd2;
  localparam logic [2:0] WAIT_LOW  = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;
  localparam logic [2:0] ADVANCE   = 3'd5;
  localparam logic [2:0] DONE      = 3'd6;

endpackage
`default_nettype wire

// File: rtl/flag_reduce.sv
`default_nettype none
// ----------------------------------------------------------------------------
// flag_reduce : registered all-high / all-low reduction of a flag vector
// Rev 1.0
// ----------------------------------------------------------------------------
module flag_reduce #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] vec,
  output logic             all_high,
  output logic             all_low
);

  always_ff @(posedge clk) begin
    if (reset) begin
      all_high <= 1'b0;
      all_low  <= 1'b0;
    end else begin
      all_high <= &vec;
      all_low  <= ~|vec;
    end
  end

endmodule
`default_nettype wire

// File: rtl/heat_sweep_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// heat_sweep_scheduler : start/done handshake sequencer for the column array
// Optional watchdog on the wait states: define SCHED_WATCHDOG_EN
// Rev 1.0
// ----------------------------------------------------------------------------
module heat_sweep_scheduler
  import heat_pkg::*;
#(
  parameter int NUM_COLS    = 16,
  parameter int ROW_W       = DEF_ROW_W,
  parameter int ITER_W      = DEF_ITER_W,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [ROW_W-1:0]    height,
  input  logic [ITER_W-1:0]   iter_limit,
  input  logic [NUM_COLS-1:0] col_init,
  input  logic [NUM_COLS-1:0] col_flag,
  output logic                start,
  output logic [ROW_W-1:0]    row_idx,
  output logic [ITER_W-1:0]   iter_count,
  output logic                sweep_done,
  output logic                busy,
  output logic                done,
  output logic                err
);

  logic [2:0]        state;
  logic [2:0]        state_next;
  logic [ROW_W-1:0]  height_q;
  logic              low_settled;
  logic              init_all;
  logic              flags_high;
  logic              flags_low;
  logic              last_row;
  logic              stop_now;
  logic [ITER_W-1:0] iter_inc;

  flag_reduce #(.WIDTH(NUM_COLS)) u_init_reduce (
    .clk      (clk),
    .reset    (reset),
    .vec      (col_init),
    .all_high (init_all),
    .all_low  ()
  );

  flag_reduce #(.WIDTH(NUM_COLS)) u_flag_reduce (
    .clk      (clk),
    .reset    (reset),
    .vec      (col_flag),
    .all_high (flags_high),
    .all_low  (flags_low)
  );

  assign last_row = (row_idx == height_q);
  assign iter_inc = iter_count + 1'b1;
  assign stop_now = ((iter_limit != '0) && (iter_inc == iter_limit)) || !run;

`ifdef SCHED_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_cnt;
  logic              waiting;
  logic              wdog_fire;

  assign waiting   = (state == INIT_WAIT) || (state == WAIT_LOW) || (state == WAIT_HIGH);
  assign wdog_fire = waiting && (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (run) state_next = INIT_WAIT;
      INIT_WAIT: if (init_all) state_next = ISSUE;
      ISSUE:     state_next = WAIT_LOW;
      // The first WAIT_LOW cycle still sees the reduced ISSUE-cycle flags.
      WAIT_LOW:  if (low_settled && flags_low) state_next = WAIT_HIGH;
      WAIT_HIGH: if (flags_high) state_next = ADVANCE;
      ADVANCE:   state_next = (last_row && stop_now) ? DONE : ISSUE;
      DONE:      if (!run) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
`ifdef SCHED_WATCHDOG_EN
    if (wdog_fire && (state_next == state)) state_next = DONE;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      row_idx     <= '0;
      iter_count  <= '0;
      height_q    <= '0;
      low_settled <= 1'b0;
    end else begin
      state       <= state_next;
      low_settled <= (state == WAIT_LOW);
      case (state)
        IDLE: begin
          if (run) begin
            height_q   <= height;
            iter_count <= '0;
            row_idx    <= '0;
          end
        end
        ADVANCE: begin
          if (last_row) begin
            row_idx    <= '0;
            iter_count <= iter_inc;
          end else begin
            row_idx    <= row_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SCHED_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (state_next != state) wdog_cnt <= '0;
      else if (waiting)        wdog_cnt <= wdog_cnt + 1'b1;
      if (wdog_fire && (state_next == DONE) && (state != ADVANCE)) err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

  assign start      = (state == ISSUE);
  assign sweep_done = (state == ADVANCE) && last_row;
  assign busy       = (state != IDLE) && (state != DONE);
  assign done       = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_heat_sweep_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_heat_sweep_scheduler : directed bench with a row/sweep expectation model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_heat_sweep_scheduler;

  localparam int NUM_COLS    = 16;
  localparam int ROW_W       = 8;
  localparam int ITER_W      = 16;
  localparam int WDOG_CYCLES = 64;

  logic                clk = 1'b0;
  logic                reset;
  logic                run;
  logic [ROW_W-1:0]    height;
  logic [ITER_W-1:0]   iter_limit;
  logic [NUM_COLS-1:0] col_init;
  logic [NUM_COLS-1:0] col_flag;
  logic                start;
  logic [ROW_W-1:0]    row_idx;
  logic [ITER_W-1:0]   iter_count;
  logic                sweep_done;
  logic                busy;
  logic                done;
  logic                err;

  heat_sweep_scheduler #(
    .NUM_COLS    (NUM_COLS),
    .ROW_W       (ROW_W),
    .ITER_W      (ITER_W),
    .WDOG_CYCLES (WDOG_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .height     (height),
    .iter_limit (iter_limit),
    .col_init   (col_init),
    .col_flag   (col_flag),
    .start      (start),
    .row_idx    (row_idx),
    .iter_count (iter_count),
    .sweep_done (sweep_done),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected (row, iteration) of every start pulse, in issue order.
  int exp_rows[$];
  int exp_iters[$];
  int exp_height  = 0;
  int sweeps_seen = 0;
  int start_cnt   = 0;
  int sweep_cnt   = 0;

  task automatic check(input string name, input longint actual, input longint required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, actual, required, $time);
    end
  endtask

  task automatic plan_run(input int h, input int limit, input int sweeps);
    exp_rows.delete();
    exp_iters.delete();
    for (int it = 0; it < sweeps; it++)
      for (int r = 0; r <= h; r++) begin
        exp_rows.push_back(r);
        exp_iters.push_back(it);
      end
    exp_height  = h;
    sweeps_seen = 0;
    start_cnt   = 0;
    sweep_cnt   = 0;
    height      = ROW_W'(h);
    iter_limit  = ITER_W'(limit);
  endtask

  // Compare process: every start and sweep_done is matched against the plan.
  always @(negedge clk) begin : compare
    int r;
    int it;
    if (!reset) begin
      check("busy_done_exclusive", busy && done, 0);
      if (start) begin
        start_cnt++;
        check("start_implies_busy", busy, 1);
        if (exp_rows.size() == 0) begin
          check("unexpected_start", 1, 0);
        end else begin
          r  = exp_rows.pop_front();
          it = exp_iters.pop_front();
          check("start_row", row_idx, r);
          check("start_iter", iter_count, it);
        end
      end
      if (sweep_done) begin
        sweep_cnt++;
        check("sweep_row", row_idx, exp_height);
        check("sweep_iter", iter_count, sweeps_seen);
        sweeps_seen++;
      end
`ifndef SCHED_WATCHDOG_EN
      check("err_tied_low", err, 0);
`endif
    end
  end

  // Column model: flag low the cycle after start, high again 5 cycles later.
  logic                auto_cols = 1'b1;
  logic [NUM_COLS-1:0] auto_flags = '0;
  int                  col_cnt = 0;
  logic                seen;
  initial begin
    forever begin
      @(negedge clk);
      seen = start;
      @(posedge clk);
      #1;
      if (reset) begin
        col_cnt    = 0;
        auto_flags = '0;
      end else if (seen) begin
        auto_flags = '0;
        col_cnt    = 5;
      end else if (col_cnt > 0) begin
        col_cnt--;
        if (col_cnt == 0) auto_flags = '1;
      end
      if (auto_cols) col_flag = auto_flags;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_start(input string name, input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!start && n < budget);
    check(name, start, 1);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check(name, done, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start"}, start, 0);
    check({tag, "_row_idx"}, row_idx, 0);
    check({tag, "_iter_count"}, iter_count, 0);
    check({tag, "_sweep_done"}, sweep_done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, required finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset      = 1'b1;
    run        = 1'b0;
    height     = '0;
    iter_limit = '0;
    col_init   = '0;
    col_flag   = '0;
    tick(3);
    check_reset_outputs("reset");
    reset = 1'b0;
    tick(2);

    // Init gating followed by one basic sweep of rows 0..3.
    col_init = 16'h7FFF;
    plan_run(3, 1, 1);
    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("init_gate_no_start", start, 0);
    end
    check("init_wait_busy", busy, 1);
    col_init = 16'hFFFF;
    n = 0;
    do begin
      tick();
      n++;
    end while (!start && n < 20);
    check("init_to_first_start", n, 2);
    n = 0;
    do begin
      tick();
      n++;
    end while (!start && n < 50);
    check("row_period_cycles", n, 9);
    wait_done("sweep1_done", 200);
    check("sweep1_row_idx", row_idx, 0);
    check("sweep1_iter_count", iter_count, 1);
    check("sweep1_starts", start_cnt, 4);
    check("sweep1_sweep_dones", sweep_cnt, 1);
    check("sweep1_plan_drained", exp_rows.size(), 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("done_holds_with_run", done, 1);
    end
    run = 1'b0;
    tick();
    check("done_to_idle_done", done, 0);
    check("done_to_idle_busy", busy, 0);

    // Several sweeps of a two-row grid, then single-row sweeps.
    plan_run(1, 3, 3);
    run = 1'b1;
    wait_done("multi_done", 400);
    check("multi_iter_count", iter_count, 3);
    check("multi_starts", start_cnt, 6);
    check("multi_sweep_dones", sweep_cnt, 3);
    run = 1'b0;
    tick(2);

    plan_run(0, 3, 3);
    run = 1'b1;
    wait_done("h0_done", 400);
    check("h0_iter_count", iter_count, 3);
    check("h0_starts", start_cnt, 3);
    check("h0_sweep_dones", sweep_cnt, 3);
    run = 1'b0;
    tick(2);

    // Stale flags: high through ISSUE must not complete the round; split highs neither.
    auto_cols = 1'b0;
    col_flag  = '1;
    plan_run(0, 1, 1);
    run = 1'b1;
    wait_start("stale_first_start", 50);
    for (int i = 0; i < 15; i++) begin
      tick();
      check("stale_no_start", start, 0);
    end
    check("stale_busy", busy, 1);
    col_flag = '0;
    tick(3);
    for (int i = 0; i < 3; i++) begin
      col_flag = 16'h00FF;
      tick();
      col_flag = 16'hFF00;
      tick();
    end
    tick();
    check("split_flags_not_done", done, 0);
    check("split_flags_no_sweep", sweep_cnt, 0);
    col_flag = '1;
    wait_done("stale_done", 20);
    check("stale_iter_count", iter_count, 1);
    check("stale_starts", start_cnt, 1);
    check("stale_sweep_dones", sweep_cnt, 1);
    run = 1'b0;
    tick(2);
    auto_cols = 1'b1;

    // Stop request during row 3 of an unlimited run finishes the sweep.
    plan_run(7, 0, 1);
    run = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(start && row_idx == 3) && n < 200);
    check("stop_reached_row3", row_idx, 3);
    tick(2);
    run = 1'b0;
    wait_done("stop_done", 200);
    check("stop_iter_count", iter_count, 1);
    check("stop_starts", start_cnt, 8);
    check("stop_sweep_dones", sweep_cnt, 1);
    check("stop_plan_drained", exp_rows.size(), 0);
    tick();
    check("stop_back_to_idle", done, 0);

    // Reset while waiting for the columns, then a fresh run.
    plan_run(5, 0, 1);
    run = 1'b1;
    wait_start("rst_first_start", 50);
    tick(4);
    check("rst_in_wait_busy", busy, 1);
    reset = 1'b1;
    run   = 1'b0;
    tick();
    check_reset_outputs("midrst");
    reset = 1'b0;
    tick(2);
    plan_run(2, 1, 1);
    run = 1'b1;
    wait_done("restart_done", 200);
    check("restart_iter_count", iter_count, 1);
    check("restart_starts", start_cnt, 3);
    run = 1'b0;
    tick(2);

`ifdef SCHED_WATCHDOG_EN
    // One stuck column: err and done exactly WDOG_CYCLES after WAIT_HIGH entry.
    auto_cols = 1'b0;
    col_flag  = '0;
    plan_run(0, 0, 1);
    run = 1'b1;
    wait_start("wdog_start", 50);
    run = 1'b0;
    tick(3);
    col_flag = 16'hFFFE;
    n = 0;
    while (!err && n < 100) begin
      tick();
      n++;
    end
    check("wdog_latency", n, 64);
    check("wdog_done", done, 1);
    tick(2);
    check("wdog_err_sticky", err, 1);
    check("wdog_idle_after", busy, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("wdog_err_cleared", err, 0);
    auto_cols = 1'b1;
    tick(2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/heat_sweep_scheduler.md
Name: heat_sweep_scheduler

Overview:
- Sequences the array of column engines: one shared `start` strobe to all columns, collects their per-row completion flags, and tracks row position and iteration count.
- Sits between the HPS/PIO control registers and the column array.
- Each handshake round advances every column by one row.
- A full sweep is rows 0..height, which equals one time step.
- Runs until an iteration limit is reached or software stops it at a sweep boundary.

Parameters:
- NUM_COLS, 16: number of column engines; width of the flag vectors.
- ROW_W, 8: row index width; matches the column row index.
- ITER_W, 16: iteration counter width.
- WDOG_CYCLES, 64: watchdog limit in cycles per handshake phase. Used only with the optional feature.

Ports:
- clk  in  1  system clock (CLOCK_50).
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = iterate, 0 = stop at the next sweep boundary.
- height  in  ROW_W  top row index; sampled on leaving IDLE.
- iter_limit  in  ITER_W  number of sweeps to run; 0 = unlimited.
- col_init  in  NUM_COLS  per-column memory-init-complete flags.
- col_flag  in  NUM_COLS  per-column row-done flags. Each column clears its flag the cycle after it sees start and sets it when its row finishes.
- start  out  1  one-cycle strobe to all columns.
- row_idx  out  ROW_W  row currently being computed.
- iter_count  out  ITER_W  number of completed sweeps.
- sweep_done  out  1  one-cycle pulse when row height completes.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE.
- err  out  1  sticky watchdog error; tied to 0 when the feature is off.

Behaviour:
- Reset values: state=IDLE; start=0; row_idx=0; iter_count=0; sweep_done=0; busy=0; done=0; err=0; height_q=0.
- IDLE: when run=1, latch height_q=height, clear iter_count and row_idx, then go to INIT_WAIT.
- INIT_WAIT: wait until &col_init. Then go to ISSUE.
- ISSUE: start=1 for exactly this cycle, then go to WAIT_LOW.
- WAIT_LOW: wait until ~|col_flag, so stale flags from the previous round are ignored. Then go to WAIT_HIGH. Minimum dwell is 1 cycle.
- WAIT_HIGH: wait until &col_flag. Then go to ADVANCE.
- ADVANCE, when row_idx != height_q:
  - row_idx += 1.
  - Go to ISSUE.
- ADVANCE, when row_idx == height_q:
  - row_idx = 0.
  - iter_count += 1.
  - Pulse sweep_done in this cycle.
  - If (iter_limit != 0 and iter_count+1 == iter_limit) or run == 0, go to DONE.
  - Otherwise go to ISSUE.
- DONE: done=1. When run is 0, return to IDLE. A run that is still held at 1 does not restart the scheduler.
- Latency per row is ISSUE (1) + WAIT_LOW (≥1) + WAIT_HIGH (column compute) + ADVANCE (1).
- Boundary cases:
  - height=0: every round is a sweep; sweep_done fires each round.
  - iter_count at all ones: wraps to 0 only when iter_limit=0.
  - run falling mid-sweep: the sweep finishes first, then the block goes to DONE. Rows are never abandoned.
  - A col_flag bit that toggles during WAIT_HIGH is not latched; all bits must be high in the same cycle.
  - reset mid-operation: all outputs return to reset values the next cycle. The columns are reset by the same signal, so no handshake is pending afterwards.
- Widths: row_idx compare is ROW_W-bit unsigned; iter_count is ITER_W-bit unsigned, modulo wrap.

Optional Feature:
- Macro: SCHED_WATCHDOG_EN.
- Defined:
  - A phase counter clears on every state entry.
  - It counts while the block is in INIT_WAIT, WAIT_LOW or WAIT_HIGH.
  - When the counter reaches WDOG_CYCLES, err is set (sticky until reset) and the block goes to DONE.
- Undefined: no counter is built, err is tied to 0, and the wait states block forever.

Decomposition:
- Shared package (heat_pkg): state encoding localparams (IDLE=0 … DONE=6); ROW_W and ITER_W defaults, shared with the column engine.
- One natural sub-module, flag_reduce: registered AND/NOR reduction of a NUM_COLS vector. Outputs all_high and all_low, with 1-cycle latency. Its latency is included in the dwell counts above; WAIT_LOW minimum becomes 2.

Test Plan:
- Init gating: col_init=0x7FFF for 10 cycles, then 0xFFFF with run=1 → no start before the all-ones cycle; first start exactly 2 cycles after it.
- One sweep, basic handshake:
  - Setup: height=3, iter_limit=1, column model clears flags 1 cycle after start and sets them 5 cycles later.
  - Required: exactly 4 start pulses; row_idx steps 0,1,2,3,0; one sweep_done; iter_count=1; done=1.
- Stale flags: col_flag held all-ones through ISSUE → no second start until flags drop low and return high.
- Stop at sweep boundary: iter_limit=0, height=7, run dropped during row 3 → rows 4–7 still issued, sweep_done pulses, DONE reached with iter_count=1.
- Reset mid-operation: reset asserted in WAIT_HIGH → next cycle state=IDLE and all outputs at reset values; a new run restarts from row 0.
- Watchdog (SCHED_WATCHDOG_EN, WDOG_CYCLES=64): one col_flag bit stuck at 0 → err=1 and done=1 exactly 64 cycles after entering WAIT_HIGH.
